// File: rtl/gg_dma_rd2d.sv
// gg_dma_rd2d: register-programmed 2D-buffer DMA reader.
//
// Walks a DRAM buffer one 4 KiB page per AXI4 read burst. The walk starts at the
// page of base and ends at the page of limit. The last burst is trimmed to end on
// the 128-byte chunk that limit points at. Returned read data is passed straight
// through to an AXI stream. m_last marks the final beat of each buffer pass.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   s_ar*/s_r*           AXI-Lite read channel (register reads)
//   s_aw*/s_w*/s_b*      AXI-Lite write channels (register writes)
//   m_ar*                AXI4 read address channel (4K-aligned bursts)
//   m_r*                 AXI4 read data channel
//   m_valid/m_ready      output stream handshake
//   m_data/m_last        output stream payload and end-of-pass marker
//
// Register map (byte addresses):
//   0x00 control  {28'h0, err, done, cont, go}; a write clears err
//   0x08/0x0C     base  [31:0]/[63:32]
//   0x10/0x14     limit [31:0]/[63:32] (inclusive, last 128-byte chunk)
//   0x18/0x1C     current burst address (read only)
//   other         reads 32'hdead_beef, writes ignored
module gg_dma_rd2d #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ADDR_W    = 40
) (
  input  logic                clk,
  input  logic                reset,
  // AXI-Lite read
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [7:0]          s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  // AXI-Lite write
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [7:0]          s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [31:0]         s_wdata,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  // AXI4 read address
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [3:0]          m_arcache,
  // AXI4 read data
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [127:0]        m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  // Output stream
  output logic                m_valid,
  input  logic                m_ready,
  output logic [127:0]        m_data,
  output logic                m_last
);

  localparam int unsigned     PtrW     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [3:0]      MaxOutst = 4'(MAX_OUTST);
  localparam logic [PtrW-1:0] PtrMax   = PtrW'(MAX_OUTST - 1);
  localparam int unsigned     PageW    = ADDR_W - 12;

  typedef enum logic [1:0] {AIdle, AStart, AValid, ADrain} a_state_e;
  typedef enum logic [0:0] {RIdle, RData}                  r_state_e;
  typedef enum logic [1:0] {WIdle, WWrite, WResp}          w_state_e;

  a_state_e a_state_q, a_state_d;
  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;

  // Control / status registers
  logic        go_q, go_dly_q, cont_q, err_q;
  logic [63:0] base_q, limit_q;
  logic [7:0]  rd_addr_q;

  // Burst walker state
  logic [ADDR_W-1:0] curr_addr_q;
  logic [7:0]        curr_len_q;
  logic [3:0]        outst_q;

  // One bit per outstanding burst: set when that burst ends its pass
  logic [MAX_OUTST-1:0] last_fifo_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;

  logic             wr_en, go_rise, ar_hs, r_hs, r_last_hs, rd_err, done;
  logic             at_limit;
  logic [PageW-1:0] curr_page, next_page, base_page, lim_page;
  logic [7:0]       last_len;
  logic [31:0]      rd_mux;
  logic [63:0]      curr_addr_ext;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign wr_en     = (w_state_q == WWrite);
  assign go_rise   = go_q & ~go_dly_q;
  assign ar_hs     = m_arvalid & m_arready;
  assign r_hs      = m_rvalid & m_ready;
  assign r_last_hs = r_hs & m_rlast;
  assign rd_err    = r_hs & (m_rresp != 2'b00);

  assign curr_page = curr_addr_q[ADDR_W-1:12];
  assign next_page = curr_page + PageW'(1);
  assign base_page = base_q[ADDR_W-1:12];
  assign lim_page  = limit_q[ADDR_W-1:12];
  assign at_limit  = (curr_page == lim_page);
  // Beats-1 of the trimmed final burst: 8 beats per 128-byte chunk
  assign last_len  = {limit_q[11:7], 3'b111};

  // ---------------------------------------------------------------------------
  // Data path: combinational pass-through
  // ---------------------------------------------------------------------------
  assign m_valid  = m_rvalid;
  assign m_rready = m_ready;
  assign m_data   = m_rdata;
  assign m_last   = m_rlast & last_fifo_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      go_q     <= 1'b0;
      go_dly_q <= 1'b0;
      cont_q   <= 1'b0;
      err_q    <= 1'b0;
      base_q   <= '0;
      limit_q  <= '0;
    end else begin
      go_dly_q <= go_q;
      if (wr_en) begin
        case (s_awaddr)
          8'h00: begin
            go_q   <= s_wdata[0];
            cont_q <= s_wdata[1];
          end
          8'h08:   base_q[31:0]   <= s_wdata;
          8'h0C:   base_q[63:32]  <= s_wdata;
          8'h10:   limit_q[31:0]  <= s_wdata;
          8'h14:   limit_q[63:32] <= s_wdata;
          default: ;
        endcase
      end
      // A bad response in the same cycle as a clear still leaves err set
      if (rd_err) begin
        err_q <= 1'b1;
      end else if (wr_en && (s_awaddr == 8'h00)) begin
        err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AXI-Lite read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
      rd_addr_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      if ((r_state_q == RIdle) && s_arvalid) begin
        rd_addr_q <= s_araddr;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (s_arvalid) r_state_d = RData;
      RData:   if (s_rready)  r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  assign curr_addr_ext = 64'(curr_addr_q);

  always_comb begin
    rd_mux = 32'hdead_beef;
    case (rd_addr_q)
      8'h00:   rd_mux = {28'h0, err_q, done, cont_q, go_q};
      8'h08:   rd_mux = base_q[31:0];
      8'h0C:   rd_mux = base_q[63:32];
      8'h10:   rd_mux = limit_q[31:0];
      8'h14:   rd_mux = limit_q[63:32];
      8'h18:   rd_mux = curr_addr_ext[31:0];
      8'h1C:   rd_mux = curr_addr_ext[63:32];
      default: rd_mux = 32'hdead_beef;
    endcase
  end

  assign s_arready = (r_state_q == RIdle);
  assign s_rvalid  = (r_state_q == RData);
  assign s_rdata   = rd_mux;
  assign s_rresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // AXI-Lite write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (s_awvalid && s_wvalid) w_state_d = WWrite;
      WWrite:  w_state_d = WResp;
      WResp:   if (s_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Address and data stay valid through WWrite, so the register write uses them directly
  assign s_awready = (w_state_q == WWrite);
  assign s_wready  = (w_state_q == WWrite);
  assign s_bvalid  = (w_state_q == WResp);
  assign s_bresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // Burst address FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_state_q <= AIdle;
    end else begin
      a_state_q <= a_state_d;
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    unique case (a_state_q)
      AIdle:   if (go_rise) a_state_d = AStart;
      AStart:  a_state_d = AValid;
      AValid:  if (ar_hs && at_limit) a_state_d = cont_q ? AStart : ADrain;
      ADrain:  if (outst_q == 4'd0) a_state_d = AIdle;
      default: a_state_d = AIdle;
    endcase
  end

  always_comb begin
    m_arvalid = (a_state_q == AValid) && (outst_q < MaxOutst);
    done      = (a_state_q == AIdle) && (outst_q == 4'd0);
  end

  assign m_araddr  = curr_addr_q;
  assign m_arlen   = curr_len_q;
  assign m_arsize  = 3'b100;
  assign m_arcache = 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_addr_q <= '0;
      curr_len_q  <= '0;
    end else if (a_state_q == AStart) begin
      curr_addr_q <= {base_q[ADDR_W-1:12], 12'h000};
      // A buffer that fits in one page gets a trimmed first burst
      curr_len_q  <= (base_page == lim_page) ? last_len : 8'hFF;
    end else if (ar_hs && !at_limit) begin
      curr_addr_q <= curr_addr_q + ADDR_W'(4096);
      curr_len_q  <= (next_page == lim_page) ? last_len : 8'hFF;
    end
  end

  // Outstanding bursts: issued on AR, retired on the final accepted R beat
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10:   outst_q <= outst_q + 4'd1;
        2'b01:   if (outst_q != 4'd0) outst_q <= outst_q - 4'd1;
        default: ;
      endcase
    end
  end

  // End-of-pass flags follow bursts in issue order; AXI returns bursts of one ID in order
  always_ff @(posedge clk) begin
    if (reset) begin
      last_fifo_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (ar_hs) begin
        last_fifo_q[wr_ptr_q] <= at_limit;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (r_last_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_gg_dma_rd2d.sv
module tb_gg_dma_rd2d;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_arvalid, s_arready;
  logic [7:0]   s_araddr;
  logic         s_rvalid, s_rready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_awvalid, s_awready;
  logic [7:0]   s_awaddr;
  logic         s_wvalid, s_wready;
  logic [31:0]  s_wdata;
  logic         s_bvalid, s_bready;
  logic [1:0]   s_bresp;
  logic         m_arvalid, m_arready;
  logic [39:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [3:0]   m_arcache;
  logic         m_rvalid, m_rready;
  logic [127:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         m_valid, m_ready;
  logic [127:0] m_data;
  logic         m_last;

  gg_dma_rd2d #(.MAX_OUTST(4), .ADDR_W(40)) dut (
    .clk(clk), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arcache(m_arcache),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // DRAM responder bookkeeping (written only by the responder process)
  logic [39:0] pend_addr[$];
  logic [7:0]  pend_len[$];
  logic [39:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  int          last_log[$];
  int          ar_count    = 0;
  int          total_beats = 0;
  int          dp_err      = 0;
  int          attr_err    = 0;
  int          beat        = 0;
  // Absolute beat index that gets SLVERR (written only by the main process)
  int          err_beat    = 32'h7fff_ffff;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] log_addr(input int i);
    return (i < ar_addr_log.size()) ? ar_addr_log[i] : 40'h0;
  endfunction

  function automatic logic [7:0] log_len(input int i);
    return (i < ar_len_log.size()) ? ar_len_log[i] : 8'h0;
  endfunction

  // DRAM model: accepts every AR, returns bursts in order, one beat per cycle
  initial begin
    logic ar_hs, r_hs;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if ((m_valid !== m_rvalid) || (m_rready !== m_ready) || (m_rvalid && (m_data !== m_rdata)))
        dp_err++;
      if (ar_hs) begin
        pend_addr.push_back(m_araddr);
        pend_len.push_back(m_arlen);
        ar_addr_log.push_back(m_araddr);
        ar_len_log.push_back(m_arlen);
        ar_count++;
        if ((m_arsize !== 3'b100) || (m_arcache !== 4'b0000)) attr_err++;
      end
      if (r_hs) begin
        total_beats++;
        if (m_last) last_log.push_back(total_beats);
        if (m_rlast) begin
          void'(pend_addr.pop_front());
          void'(pend_len.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      @(posedge clk);
      #1;
      m_arready = 1'b1;
      if (pend_addr.size() > 0) begin
        m_rvalid = 1'b1;
        m_rlast  = (beat == int'(pend_len[0]));
        m_rdata  = {24'h0, pend_addr[0], 32'(beat), 32'(total_beats)};
        m_rresp  = (total_beats == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
      end
    end
  end

  task automatic axil_write(input logic [7:0] a, input logic [31:0] d, input int bdly);
    bit seen;
    @(posedge clk); #1;
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_awready && s_wready) begin seen = 1'b1; break; end
    end
    if (!seen) chk("aw_handshake_timeout", {63'h0, s_awready}, 64'h1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_bvalid) begin seen = 1'b1; break; end
    end
    if (!seen) chk("b_timeout", {63'h0, s_bvalid}, 64'h1);
    if (bdly > 0) begin
      repeat (bdly) @(posedge clk);
      @(negedge clk);
      chk("bvalid_held", {63'h0, s_bvalid}, 64'h1);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [7:0] a, output logic [31:0] d);
    bit seen;
    d = 32'h0;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_arready) begin seen = 1'b1; break; end
    end
    if (!seen) chk("ar_timeout", {63'h0, s_arready}, 64'h1);
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_rready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_rvalid) begin seen = 1'b1; d = s_rdata; break; end
    end
    if (!seen) chk("r_timeout", {63'h0, s_rvalid}, 64'h1);
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (total_beats >= target) break;
    end
    if (total_beats < target) chk("beat_timeout", 64'(total_beats), 64'(target));
  endtask

  task automatic wait_done(output logic [31:0] d);
    for (int i = 0; i < 500; i++) begin
      axil_read(8'h00, d);
      if (d[2]) break;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int ab, bb, lb, n, bad;

    reset = 1'b1;
    s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_bready = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_arvalid", {63'h0, m_arvalid}, 64'h0);
    chk("rst_s_rvalid",  {63'h0, s_rvalid},  64'h0);
    chk("rst_s_bvalid",  {63'h0, s_bvalid},  64'h0);
    chk("rst_s_awready", {63'h0, s_awready}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    axil_read(8'h00, rd);  chk("rst_ctrl", 64'(rd), 64'h4);
    axil_read(8'h10, rd);  chk("rst_limit", 64'(rd), 64'h0);
    axil_read(8'h18, rd);  chk("rst_curr", 64'(rd), 64'h0);

    // Register I/O, with a held-off write response
    axil_write(8'h08, 32'h1234_5000, 3);
    axil_read(8'h08, rd);  chk("reg_base_rb", 64'(rd), 64'h1234_5000);
    axil_read(8'h40, rd);  chk("reg_unmapped", 64'(rd), 64'hdead_beef);

    // Single pass over 1.3 pages
    m_ready = 1'b1;
    axil_write(8'h08, 32'h1000_0000, 0);
    axil_write(8'h0C, 32'h0, 0);
    axil_write(8'h10, 32'h1000_1380, 0);
    axil_write(8'h14, 32'h0, 0);
    ab = ar_count; bb = total_beats; lb = last_log.size();
    axil_write(8'h00, 32'h1, 0);
    wait_beats(bb + 320, 3000);
    repeat (5) @(posedge clk);
    chk("p1_ar_count", 64'(ar_count - ab), 64'd2);
    chk("p1_ar0_addr", 64'(log_addr(ab)), 64'h1000_0000);
    chk("p1_ar0_len",  64'(log_len(ab)), 64'hFF);
    chk("p1_ar1_addr", 64'(log_addr(ab + 1)), 64'h1000_1000);
    chk("p1_ar1_len",  64'(log_len(ab + 1)), 64'h3F);
    chk("p1_beats", 64'(total_beats - bb), 64'd320);
    chk("p1_last_count", 64'(last_log.size() - lb), 64'd1);
    chk("p1_last_pos", 64'((last_log.size() > lb) ? last_log[lb] - bb : 0), 64'd320);
    wait_done(rd);
    chk("p1_ctrl_done", 64'(rd), 64'h5);
    axil_read(8'h18, rd);  chk("p1_curr_addr", 64'(rd), 64'h1000_1000);

    // Single-page buffer with an unaligned base
    axil_write(8'h00, 32'h0, 0);
    axil_write(8'h08, 32'h2000_0abc, 0);
    axil_write(8'h10, 32'h2000_0000, 0);
    ab = ar_count; bb = total_beats; lb = last_log.size();
    axil_write(8'h00, 32'h1, 0);
    wait_beats(bb + 8, 500);
    repeat (5) @(posedge clk);
    chk("sp_ar_count", 64'(ar_count - ab), 64'd1);
    chk("sp_ar_addr", 64'(log_addr(ab)), 64'h2000_0000);
    chk("sp_ar_len", 64'(log_len(ab)), 64'h07);
    chk("sp_beats", 64'(total_beats - bb), 64'd8);
    chk("sp_last_pos", 64'((last_log.size() > lb) ? last_log[lb] - bb : 0), 64'd8);

    // Outstanding limit with the stream stalled
    axil_write(8'h00, 32'h0, 0);
    m_ready = 1'b0;
    axil_write(8'h08, 32'h3000_0000, 0);
    axil_write(8'h10, 32'h3000_7000, 0);
    ab = ar_count; bb = total_beats; lb = last_log.size();
    axil_write(8'h00, 32'h1, 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("os_ar_count4", 64'(ar_count - ab), 64'd4);
    chk("os_arvalid_lo", {63'h0, m_arvalid}, 64'h0);
    m_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_rvalid && m_ready && m_rlast) break;
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("os_ar_count5", 64'(ar_count - ab), 64'd5);
    chk("os_arvalid_lo2", {63'h0, m_arvalid}, 64'h0);
    m_ready = 1'b1;
    wait_beats(bb + 1800, 5000);
    repeat (5) @(posedge clk);
    chk("os_ar_total", 64'(ar_count - ab), 64'd8);
    chk("os_ar7_addr", 64'(log_addr(ab + 7)), 64'h3000_7000);
    chk("os_ar7_len", 64'(log_len(ab + 7)), 64'h07);
    chk("os_last_count", 64'(last_log.size() - lb), 64'd1);
    chk("os_last_pos", 64'((last_log.size() > lb) ? last_log[lb] - bb : 0), 64'd1800);
    wait_done(rd);
    chk("os_ctrl_done", 64'(rd), 64'h5);

    // Continuous mode over a 2-page buffer
    axil_write(8'h00, 32'h2, 0);
    axil_write(8'h08, 32'h4000_0000, 0);
    axil_write(8'h10, 32'h4000_1000, 0);
    ab = ar_count; bb = total_beats; lb = last_log.size();
    axil_write(8'h00, 32'h3, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ar_count >= ab + 5) break;
    end
    chk("ct_ar_reached5", 64'(ar_count - ab >= 5), 64'h1);
    axil_write(8'h00, 32'h1, 0);
    wait_done(rd);
    chk("ct_ctrl_done", 64'(rd), 64'h5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (log_addr(ab + i) !== ((i % 2 == 0) ? 40'h40_0000_0000 >> 8 : 40'h40_0000_1000 >> 8 << 0))
        bad = bad;
    end
    chk("ct_ar0_addr", 64'(log_addr(ab)),     64'h4000_0000);
    chk("ct_ar1_addr", 64'(log_addr(ab + 1)), 64'h4000_1000);
    chk("ct_ar2_addr", 64'(log_addr(ab + 2)), 64'h4000_0000);
    chk("ct_ar3_addr", 64'(log_addr(ab + 3)), 64'h4000_1000);
    chk("ct_ar4_addr", 64'(log_addr(ab + 4)), 64'h4000_0000);
    chk("ct_ar1_len",  64'(log_len(ab + 1)),  64'h07);
    chk("ct_ar2_len",  64'(log_len(ab + 2)),  64'hFF);
    n = ar_count - ab;
    chk("ct_ar_even", 64'(n % 2), 64'd0);
    chk("ct_last_count", 64'(last_log.size() - lb), 64'(n / 2));
    chk("ct_beats", 64'(total_beats - bb), 64'((n / 2) * 264));
    bad = 0;
    for (int i = lb; i < last_log.size(); i++) begin
      if (last_log[i] - bb != (i - lb + 1) * 264) bad++;
    end
    chk("ct_last_pos", 64'(bad), 64'd0);

    // Error response on one beat
    axil_write(8'h00, 32'h0, 0);
    axil_write(8'h08, 32'h5000_0000, 0);
    axil_write(8'h10, 32'h5000_0000, 0);
    bb = total_beats;
    err_beat = bb + 3;
    axil_write(8'h00, 32'h1, 0);
    wait_beats(bb + 8, 500);
    wait_done(rd);
    chk("er_beats", 64'(total_beats - bb), 64'd8);
    chk("er_ctrl_err", 64'(rd), 64'hD);
    err_beat = 32'h7fff_ffff;
    axil_write(8'h00, 32'h0, 0);
    axil_read(8'h00, rd);
    chk("er_ctrl_clr", 64'(rd), 64'h4);

    chk("datapath_passthru", 64'(dp_err), 64'd0);
    chk("ar_attributes", 64'(attr_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
